axi_mem_slave: RTL and testbench
================================

# axi_mem_slave

AXI4 responder that terminates one `AXI_BUS.Slave` port on an internal word-addressed memory array. It is the simulation/boot-memory endpoint behind the crossbar: it completes read and write bursts (FIXED/INCR/WRAP), applies write strobes, and reports OKAY or SLVERR. Read and write channels run independently, one outstanding transaction per direction.

## Interface
- `AXI_ADDR_WIDTH`, 64: address width of `slv`.
- `AXI_DATA_WIDTH`, 64: data width; `STRB = AXI_DATA_WIDTH/8`, `OFS = log2(STRB)`.
- `AXI_ID_WIDTH`, 4: ID width.
- `AXI_USER_WIDTH`, 1: user width.
- `MEM_WORDS`, 1024: array depth in data words; word index = `addr[AXI_ADDR_WIDTH-1:OFS]`.
- `clk_i`  in  1  clock; all logic on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `slv`  AXI_BUS.Slave  (params above)  full AXI4 slave port: AW, W, B, AR, R channels.

## Operation
- Array: `MEM_WORDS` x `AXI_DATA_WIDTH`, not reset; per-byte write enables from `w_strb`.
- Write FSM `W_IDLE -> W_DATA -> W_RESP -> W_IDLE`:
  - W_IDLE: `aw_ready=1`. On AW handshake latch id/addr/len/size/burst, clear beat counter and error flag, go W_DATA.
  - W_DATA: `w_ready=1`. Each W handshake writes enabled bytes at the current word index, unless errored; address advances; counter increments. Leave on a beat with `w_last=1`.
  - W_RESP: `b_valid=1`, `b_id`=latched id, `b_resp`=OKAY(00) or SLVERR(10). On `b_ready`, go W_IDLE.
- Read FSM `R_IDLE -> R_DATA -> R_IDLE`:
  - R_IDLE: `ar_ready=1`. On AR handshake latch fields, go R_DATA.
  - R_DATA: `r_valid=1`, `r_data`=array[current index] (0 if out of range), `r_id`=latched id, `r_last=(count==len)`. Each R handshake advances address and counter; the `r_last` handshake returns to R_IDLE.
- Address update per beat, with `nb = 1<<size`:
  - FIXED(00): unchanged.
  - INCR(01) and reserved(11): `addr+nb`.
  - WRAP(10): `addr+nb` wrapped within aligned block of `(len+1)*nb` bytes.
  - Arithmetic is in `AXI_ADDR_WIDTH` bits, wrapping mod 2^width.
- SLVERR conditions. Writes are dropped; reads return data 0.
  - Word index >= `MEM_WORDS` on any beat (per-beat for reads, sticky for the write response).
  - `size > OFS`.
  - AW with `aw_atop != 0`. All W beats are still consumed.
  - Write `w_last` on a beat other than beat `len`.
  - Missing `w_last` on beat `len`: keep accepting until `w_last`; extra beats are not written.
- Narrow transfers: no lane realignment; `r_data` is the full word; master strobes select lanes.
- `b_user`, `r_user` are tied 0. `aw_region`, `qos`, `cache`, `prot`, `lock` and user inputs are ignored.

## Timing
- Reset (and while `rst_ni=0`): both FSMs idle.
  - Outputs: `aw_ready=1`, `ar_ready=1`, `w_ready=0`, `b_valid=0`, `r_valid=0`.
  - `b_id`, `b_resp`, `r_id`, `r_resp`, `r_last` = 0. `r_data` = 0 while `r_valid=0`.
- Latencies:
  - AR handshake at cycle N: first `r_valid` at N+1; back-to-back beats at one per cycle while `r_ready=1`.
  - AW handshake at N: `w_ready` from N+1.
  - Last W beat at M: `b_valid` at M+1.
  - After the final R/B handshake, the next `ar_ready`/`aw_ready` is at the following cycle (one bubble).
- Backpressure: `r_valid`/`b_valid` and all payloads stay stable until handshake.
- A write and a read to the same word in the same cycle: R returns the pre-write value; the write lands at the edge.
- Reset mid-burst: FSMs return to idle immediately. Already-written beats persist; the remainder of the transaction is abandoned with no B/R.

## Test plan
- INCR write, then INCR read, both `addr=0x100, len=3, size=3`:
  - Write data 0x11..11, 0x22..22, 0x33..33, 0x44..44; `w_strb=0xFF`, `w_last` on beat 3.
  - B: `b_resp=00`, `b_id`=AW id.
  - R: same four words with `r_resp=00`; `r_last` only on the 4th beat; first `r_valid` one cycle after AR.
- Strobes at `0x200`: write 0xFFFFFFFF_FFFFFFFF, then data 0 with `w_strb=0x0F`. Read returns 0xFFFFFFFF_00000000.
- WRAP read `addr=0x118, len=3, size=3`: returns words at 0x118, 0x100, 0x108, 0x110. FIXED `len=2` returns the same word three times.
- Out-of-range read at `MEM_WORDS*8`, `len=1`: two beats, `r_data=0`, `r_resp=10`. Write with `aw_atop=6'h20` consumes all beats, `b_resp=10`, memory unchanged.
- Backpressure:
  - Hold `b_ready=0` for 5 cycles: `b_valid`, `b_id`, `b_resp` stable; `aw_ready=0` throughout.
  - Toggle `r_ready` every cycle on a `len=7` read: 8 beats in order with correct `r_last`.
- Assert `rst_ni=0` after beat 1 of a `len=3` write:
  - Outputs go to reset values asynchronously.
  - After release, reading `len=3` returns beats 0-1 written and beats 2-3 unchanged.

Source files
------------

// File: rtl/axi_mem_slave_if.sv
// AXI_BUS: AXI4 bus bundle (AW, W, B, AR, R) with master and slave views
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [2:0]                  aw_prot;
    logic [3:0]                  aw_qos;
    logic [3:0]                  aw_region;
    logic [5:0]                  aw_atop;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;
    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;
    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;
    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [2:0]                  ar_prot;
    logic [3:0]                  ar_qos;
    logic [3:0]                  ar_region;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;
    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
               aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
               ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI4 responder on a word-addressed memory, one outstanding burst per direction
module axi_mem_slave #(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 64,
    parameter int unsigned AXI_ID_WIDTH   = 4,
    parameter int unsigned AXI_USER_WIDTH = 1,
    parameter int unsigned MEM_WORDS      = 1024
) (
    input logic   clk_i,
    input logic   rst_ni,
    AXI_BUS.Slave slv
);
    localparam int unsigned STRB = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFS  = $clog2(STRB);
    localparam int unsigned IW   = $clog2(MEM_WORDS);
    localparam int unsigned AW   = AXI_ADDR_WIDTH;
    localparam logic [2:0]  MAX_SIZE = 3'(OFS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    logic [AXI_DATA_WIDTH-1:0] r_mem [MEM_WORDS];

    function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] a, input logic [7:0] len,
                                                  input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] nb, msk;
        nb  = AW'(1) << size;
        msk = ((AW'(len) + AW'(1)) << size) - AW'(1);
        return (burst == 2'b00) ? a :
               (burst == 2'b10) ? ((a & ~msk) | ((a + nb) & msk)) : a + nb;
    endfunction

    wstate_e                 r_wstate, w_wstate_nxt;
    logic [AXI_ID_WIDTH-1:0] r_aw_id;
    logic [AW-1:0]           r_aw_addr;
    logic [7:0]              r_aw_len, r_wcnt;
    logic [2:0]              r_aw_size;
    logic [1:0]              r_aw_burst;
    logic                    r_werr;
    logic                    w_aw_hs, w_w_hs, w_woob, w_wbad, w_we;
    logic [IW-1:0]           w_widx;

    rstate_e                 r_rstate, w_rstate_nxt;
    logic [AXI_ID_WIDTH-1:0] r_ar_id;
    logic [AW-1:0]           r_ar_addr;
    logic [7:0]              r_ar_len, r_rcnt;
    logic [2:0]              r_ar_size;
    logic [1:0]              r_ar_burst;
    logic                    r_rerr;
    logic                    w_ar_hs, w_r_hs, w_roob, w_rbad, w_rlast;
    logic [IW-1:0]           w_ridx;

    logic                    w_unused;

    assign w_aw_hs = slv.aw_valid & slv.aw_ready;
    assign w_w_hs  = slv.w_valid & slv.w_ready;
    assign w_woob  = (r_aw_addr >> OFS) >= AW'(MEM_WORDS);
    assign w_widx  = r_aw_addr[OFS +: IW];
    // a beat is dropped once the burst has errored, when out of range, or on an early w_last
    assign w_wbad  = r_werr | w_woob | (slv.w_last & (r_wcnt != r_aw_len));
    assign w_we    = w_w_hs & ~w_wbad;

    assign slv.b_id   = r_aw_id;
    assign slv.b_resp = (slv.b_valid & r_werr) ? 2'b10 : 2'b00;
    assign slv.b_user = '0;

    // write FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_wstate <= W_IDLE;
        else         r_wstate <= w_wstate_nxt;
    end

    // write FSM next state and handshake outputs
    always_comb begin
        w_wstate_nxt  = r_wstate;
        slv.aw_ready  = 1'b0;
        slv.w_ready   = 1'b0;
        slv.b_valid   = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                slv.aw_ready = 1'b1;
                if (slv.aw_valid) w_wstate_nxt = W_DATA;
            end
            W_DATA: begin
                slv.w_ready = 1'b1;
                if (slv.w_valid && slv.w_last) w_wstate_nxt = W_RESP;
            end
            W_RESP: begin
                slv.b_valid = 1'b1;
                if (slv.b_ready) w_wstate_nxt = W_IDLE;
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // write burst context: latched AW fields, beat address/count and sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_aw_id    <= '0;
            r_aw_addr  <= '0;
            r_aw_len   <= '0;
            r_aw_size  <= '0;
            r_aw_burst <= '0;
            r_wcnt     <= '0;
            r_werr     <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_id    <= slv.aw_id;
                r_aw_addr  <= slv.aw_addr;
                r_aw_len   <= slv.aw_len;
                r_aw_size  <= slv.aw_size;
                r_aw_burst <= slv.aw_burst;
                r_wcnt     <= '0;
                r_werr     <= (slv.aw_size > MAX_SIZE) | (slv.aw_atop != '0);
            end
            if (w_w_hs) begin
                r_aw_addr <= f_next_addr(r_aw_addr, r_aw_len, r_aw_size, r_aw_burst);
                r_wcnt    <= r_wcnt + 8'd1;
                r_werr    <= w_wbad | ((r_wcnt == r_aw_len) & ~slv.w_last);
            end
        end
    end

    // byte-lane writes into the array, which is deliberately left unreset
    always_ff @(posedge clk_i) begin
        if (w_we) begin
            for (int b = 0; b < STRB; b++) begin
                if (slv.w_strb[b]) r_mem[w_widx][8*b +: 8] <= slv.w_data[8*b +: 8];
            end
        end
    end

    assign w_ar_hs = slv.ar_valid & slv.ar_ready;
    assign w_r_hs  = slv.r_valid & slv.r_ready;
    assign w_roob  = (r_ar_addr >> OFS) >= AW'(MEM_WORDS);
    assign w_ridx  = r_ar_addr[OFS +: IW];
    assign w_rbad  = r_rerr | w_roob;
    assign w_rlast = r_rcnt == r_ar_len;

    // combinational array read, so a same-cycle write is seen only after the edge
    assign slv.r_data = (slv.r_valid & ~w_rbad) ? r_mem[w_ridx] : '0;
    assign slv.r_resp = (slv.r_valid & w_rbad) ? 2'b10 : 2'b00;
    assign slv.r_last = slv.r_valid & w_rlast;
    assign slv.r_id   = r_ar_id;
    assign slv.r_user = '0;

    // read FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_rstate <= R_IDLE;
        else         r_rstate <= w_rstate_nxt;
    end

    // read FSM next state and handshake outputs
    always_comb begin
        w_rstate_nxt = r_rstate;
        slv.ar_ready = 1'b0;
        slv.r_valid  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                slv.ar_ready = 1'b1;
                if (slv.ar_valid) w_rstate_nxt = R_DATA;
            end
            R_DATA: begin
                slv.r_valid = 1'b1;
                if (slv.r_ready && w_rlast) w_rstate_nxt = R_IDLE;
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // read burst context: latched AR fields, beat address/count and unsupported-size flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ar_id    <= '0;
            r_ar_addr  <= '0;
            r_ar_len   <= '0;
            r_ar_size  <= '0;
            r_ar_burst <= '0;
            r_rcnt     <= '0;
            r_rerr     <= 1'b0;
        end else begin
            if (w_ar_hs) begin
                r_ar_id    <= slv.ar_id;
                r_ar_addr  <= slv.ar_addr;
                r_ar_len   <= slv.ar_len;
                r_ar_size  <= slv.ar_size;
                r_ar_burst <= slv.ar_burst;
                r_rcnt     <= '0;
                r_rerr     <= slv.ar_size > MAX_SIZE;
            end
            if (w_r_hs) begin
                r_ar_addr <= f_next_addr(r_ar_addr, r_ar_len, r_ar_size, r_ar_burst);
                r_rcnt    <= r_rcnt + 8'd1;
            end
        end
    end

    assign w_unused = ^{slv.aw_lock, slv.aw_cache, slv.aw_prot, slv.aw_qos, slv.aw_region,
                        slv.aw_user, slv.w_user, slv.ar_lock, slv.ar_cache, slv.ar_prot,
                        slv.ar_qos, slv.ar_region, slv.ar_user};
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: randomized AXI4 bursts against a byte-level memory model
module tb_axi_mem_slave;
    localparam int MW = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    logic [63:0] mdl [MW];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    always #5 clk = ~clk;

    AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) slv ();

    axi_mem_slave #(
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1), .MEM_WORDS(MW)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .slv   (slv)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // byte address of beat i, straight from the burst-type definitions
    function automatic logic [63:0] beat_addr(input logic [63:0] a, input int len, input int size,
                                              input logic [1:0] burst, input int i);
        logic [63:0] nb, blk, base;
        nb   = 64'd1 << size;
        blk  = 64'(len + 1) * nb;
        base = a - (a % blk);
        if (burst == 2'b00) return a;
        if (burst == 2'b10) return base + ((a - base + 64'(i) * nb) % blk);
        return a + 64'(i) * nb;
    endfunction

    task automatic write_burst(input logic [3:0] id, input logic [63:0] addr, input int len,
                               input int size, input logic [1:0] burst, input logic [5:0] atop,
                               input int last_at, input int hold, input int abort);
        logic        err, bad;
        logic [63:0] a;
        int          t;
        err = (atop != 0) || (size > 3);
        @(posedge clk); #1;
        slv.aw_id = id; slv.aw_addr = addr; slv.aw_len = 8'(len); slv.aw_size = 3'(size);
        slv.aw_burst = burst; slv.aw_atop = atop; slv.aw_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!slv.aw_ready && t < 20);
        check("aw_ready", slv.aw_ready, 1);
        @(posedge clk); #1;
        slv.aw_valid = 1'b0;
        for (int i = 0; i <= last_at; i++) begin
            slv.w_valid = 1'b1; slv.w_data = wd[i]; slv.w_strb = ws[i]; slv.w_last = (i == last_at);
            @(negedge clk);
            check("w_ready", slv.w_ready, 1);
            a   = beat_addr(addr, len, size, burst, i);
            bad = err || ((a >> 3) >= MW) || (i == last_at && i != len);
            if (!bad) for (int b = 0; b < 8; b++) if (ws[i][b]) mdl[a >> 3][8*b +: 8] = wd[i][8*b +: 8];
            err = bad || (i == len && i != last_at);
            @(posedge clk); #1;
            if (i == abort) begin
                rst_n = 1'b0; slv.w_valid = 1'b0; slv.w_last = 1'b0;
                #1;
                check("rst_aw_ready", slv.aw_ready, 1);
                check("rst_ar_ready", slv.ar_ready, 1);
                check("rst_w_ready", slv.w_ready, 0);
                check("rst_b_valid", slv.b_valid, 0);
                check("rst_r_valid", slv.r_valid, 0);
                check("rst_b_id", slv.b_id, 0);
                check("rst_b_resp", slv.b_resp, 0);
                check("rst_r_data", slv.r_data, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                return;
            end
        end
        slv.w_valid = 1'b0; slv.w_last = 1'b0;
        for (int k = 0; k <= hold; k++) begin
            @(negedge clk);
            check("b_valid", slv.b_valid, 1);
            check("b_id", slv.b_id, 64'(id));
            check("b_resp", slv.b_resp, err ? 64'd2 : 64'd0);
            check("aw_blocked", slv.aw_ready, 0);
        end
        slv.b_ready = 1'b1;
        @(posedge clk); #1;
        slv.b_ready = 1'b0;
        @(negedge clk);
        check("b_done", slv.b_valid, 0);
        check("aw_after_b", slv.aw_ready, 1);
    endtask

    task automatic read_burst(input logic [3:0] id, input logic [63:0] addr, input int len,
                              input int size, input logic [1:0] burst, input bit tog);
        logic [63:0] a;
        logic        bad, hs;
        int          t;
        @(posedge clk); #1;
        slv.ar_id = id; slv.ar_addr = addr; slv.ar_len = 8'(len); slv.ar_size = 3'(size);
        slv.ar_burst = burst; slv.ar_valid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!slv.ar_ready && t < 20);
        check("ar_ready", slv.ar_ready, 1);
        @(posedge clk); #1;
        slv.ar_valid = 1'b0; slv.r_ready = 1'b1;
        for (int i = 0; i <= len; i++) begin
            t = 0; hs = 1'b0;
            while (!hs && t < 20) begin
                @(negedge clk);
                if (i == 0 && t == 0) check("r_first", slv.r_valid, 1);
                hs = slv.r_valid && slv.r_ready;
                if (!hs) begin
                    @(posedge clk); #1;
                    if (tog) slv.r_ready = ~slv.r_ready;
                end
                t++;
            end
            check("r_hs", hs, 1);
            a   = beat_addr(addr, len, size, burst, i);
            bad = (size > 3) || ((a >> 3) >= MW);
            check("r_data", slv.r_data, bad ? 64'd0 : mdl[a >> 3]);
            check("r_resp", slv.r_resp, bad ? 64'd2 : 64'd0);
            check("r_last", slv.r_last, (i == len) ? 64'd1 : 64'd0);
            check("r_id", slv.r_id, 64'(id));
            @(posedge clk); #1;
            if (tog) slv.r_ready = ~slv.r_ready;
        end
        slv.r_ready = 1'b0;
        @(negedge clk);
        check("r_done", slv.r_valid, 0);
        check("ar_after_r", slv.ar_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] addr, nb;
        int          len, sz;
        logic [1:0]  bu;
        slv.aw_id = '0; slv.aw_addr = '0; slv.aw_len = '0; slv.aw_size = '0; slv.aw_burst = '0;
        slv.aw_lock = 1'b0; slv.aw_cache = '0; slv.aw_prot = '0; slv.aw_qos = '0; slv.aw_region = '0;
        slv.aw_atop = '0; slv.aw_user = '0; slv.aw_valid = 1'b0;
        slv.w_data = '0; slv.w_strb = '0; slv.w_last = 1'b0; slv.w_user = '0; slv.w_valid = 1'b0;
        slv.b_ready = 1'b0;
        slv.ar_id = '0; slv.ar_addr = '0; slv.ar_len = '0; slv.ar_size = '0; slv.ar_burst = '0;
        slv.ar_lock = 1'b0; slv.ar_cache = '0; slv.ar_prot = '0; slv.ar_qos = '0; slv.ar_region = '0;
        slv.ar_user = '0; slv.ar_valid = 1'b0; slv.r_ready = 1'b0;
        #3;
        check("reset_aw_ready", slv.aw_ready, 1);
        check("reset_ar_ready", slv.ar_ready, 1);
        check("reset_w_ready", slv.w_ready, 0);
        check("reset_b_valid", slv.b_valid, 0);
        check("reset_r_valid", slv.r_valid, 0);
        check("reset_r_data", slv.r_data, 0);
        check("reset_r_last", slv.r_last, 0);
        check("reset_r_resp", slv.r_resp, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 128; i++) begin
            wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF;
        end
        write_burst(4'h1, 64'h0, 127, 3, 2'b01, 6'h0, 127, 0, -1);
        for (int i = 0; i < 4; i++) begin
            wd[i] = {16{4'(i + 1)}}; ws[i] = 8'hFF;
        end
        write_burst(4'h3, 64'h100, 3, 3, 2'b01, 6'h0, 3, 0, -1);
        read_burst(4'h5, 64'h100, 3, 3, 2'b01, 1'b0);
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        write_burst(4'h7, 64'h200, 0, 3, 2'b01, 6'h0, 0, 0, -1);
        wd[0] = 64'h0; ws[0] = 8'h0F;
        write_burst(4'h7, 64'h200, 0, 3, 2'b01, 6'h0, 0, 0, -1);
        read_burst(4'h2, 64'h200, 0, 3, 2'b01, 1'b0);
        read_burst(4'h9, 64'h118, 3, 3, 2'b10, 1'b0);
        read_burst(4'hA, 64'h108, 2, 3, 2'b00, 1'b0);
        read_burst(4'hB, 64'(MW * 8), 1, 3, 2'b01, 1'b0);
        read_burst(4'hC, 64'h100, 0, 4, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF;
        end
        write_burst(4'h2, 64'h100, 3, 3, 2'b01, 6'h20, 3, 0, -1);
        read_burst(4'h2, 64'h100, 3, 3, 2'b01, 1'b0);
        write_burst(4'hD, 64'h300, 1, 3, 2'b01, 6'h0, 1, 5, -1);
        read_burst(4'hE, 64'h180, 7, 3, 2'b01, 1'b1);
        write_burst(4'h4, 64'h140, 3, 3, 2'b01, 6'h0, 1, 0, -1);
        read_burst(4'h4, 64'h140, 3, 3, 2'b01, 1'b0);
        write_burst(4'h6, 64'h160, 1, 3, 2'b01, 6'h0, 3, 0, -1);
        read_burst(4'h6, 64'h160, 3, 3, 2'b01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF;
        end
        write_burst(4'h8, 64'h380, 3, 3, 2'b01, 6'h0, 3, 0, 1);
        read_burst(4'h8, 64'h380, 3, 3, 2'b01, 1'b0);
        for (int n = 0; n < 25; n++) begin
            sz   = $urandom_range(0, 3);
            nb   = 64'd1 << sz;
            bu   = 2'($urandom_range(0, 3));
            len  = (bu == 2'b10) ? (1 << $urandom_range(1, 4)) - 1 : $urandom_range(0, 15);
            addr = 64'($urandom_range(0, 'h37F)) & ~(nb - 1);
            for (int i = 0; i <= len; i++) begin
                wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom);
            end
            write_burst(4'($urandom), addr, len, sz, bu, 6'h0, len, $urandom_range(0, 2), -1);
            sz   = $urandom_range(0, 3);
            nb   = 64'd1 << sz;
            bu   = 2'($urandom_range(0, 3));
            len  = (bu == 2'b10) ? (1 << $urandom_range(1, 4)) - 1 : $urandom_range(0, 15);
            addr = 64'($urandom_range(0, 'h37F)) & ~(nb - 1);
            read_burst(4'($urandom), addr, len, sz, bu, 1'($urandom));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
